// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Write-back scheduler and register scoreboard for the 32x32 integer
//   register file. The ALU and load/store unit share the single write port
//   (we3/ad3/wd3). The LSU normally wins contention, but an ALU that has
//   been denied STARVE_MAX consecutive cycles is granted next. A pending bit
//   per architectural register tracks outstanding writes, and hazard stalls
//   decode until the write has committed.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   iss_valid, iss_rd      decode issues an instruction writing iss_rd
//   rs1_ad, rs2_ad, dec_rd decode source/destination addresses for hazard check
//   hazard                 combinational stall request to decode
//   alu_valid/rd/wd/ready  ALU writeback handshake
//   lsu_valid/rd/wd/ready  load writeback handshake
//   we3, ad3, wd3          registered register-file write port
//   busy                   at least one register has a pending write
module regfile_wb_sched #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [4:0]      rs1_ad,
  input  logic [4:0]      rs2_ad,
  input  logic [4:0]      dec_rd,
  output logic            hazard,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            lsu_ready,
  output logic            we3,
  output logic [4:0]      ad3,
  output logic [XLEN-1:0] wd3,
  output logic            busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [31:0]     pend_reg, pend_next;
  logic [3:0]      starve_cnt_reg, starve_cnt_next;
  logic            we3_reg;
  logic [4:0]      ad3_reg;
  logic [XLEN-1:0] wd3_reg;

  logic            alu_grant, lsu_grant, xfer, commit_next;
  logic [4:0]      xfer_rd;
  logic [XLEN-1:0] xfer_wd;

  // Grants are gated by rst_n so that neither source sees a handshake
  // while the block is held in reset.
  always_comb begin
    alu_grant = rst_n & alu_valid & (~lsu_valid | (starve_cnt_reg == STARVE_LIM));
    lsu_grant = rst_n & lsu_valid & ~alu_grant;
    xfer      = alu_grant | lsu_grant;
    xfer_rd   = alu_grant ? alu_rd : lsu_rd;
    xfer_wd   = alu_grant ? alu_wd : lsu_wd;
    // A transfer to x0 completes the handshake but never reaches the file.
    commit_next = xfer & (xfer_rd != 5'd0);
  end

  // Starvation counter: counts consecutive denied ALU cycles, saturating.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (alu_valid && !alu_grant) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? starve_cnt_reg
                                                       : starve_cnt_reg + 4'd1;
    end
  end

  // Scoreboard: the set term is ORed in after the clear, so a new producer
  // issued in the same cycle its predecessor commits keeps the bit set.
  assign pend_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pend
      assign pend_next[gi] = (iss_valid && (iss_rd == 5'(gi))) |
                             (pend_reg[gi] & ~(we3_reg && (ad3_reg == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg       <= '0;
      starve_cnt_reg <= '0;
      we3_reg        <= 1'b0;
      ad3_reg        <= '0;
      wd3_reg        <= '0;
    end else begin
      pend_reg       <= pend_next;
      starve_cnt_reg <= starve_cnt_next;
      we3_reg        <= commit_next;
      // Address/data only move on a real commit; otherwise they hold.
      if (commit_next) begin
        ad3_reg <= xfer_rd;
        wd3_reg <= xfer_wd;
      end
    end
  end

  assign hazard = ((rs1_ad != 5'd0) & pend_reg[rs1_ad]) |
                  ((rs2_ad != 5'd0) & pend_reg[rs2_ad]) |
                  ((dec_rd != 5'd0) & pend_reg[dec_rd]);

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;
  assign we3       = we3_reg;
  assign ad3       = ad3_reg;
  assign wd3       = wd3_reg;
  assign busy      = |pend_reg;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched. Expected register-file commits
// are pushed to a scoreboard queue when a handshake is driven and popped
// and compared one cycle later against we3/ad3/wd3.
module tb_regfile_wb_sched;

  localparam int XLEN       = 32;
  localparam int STARVE_MAX = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid;
  logic [4:0]      iss_rd, rs1_ad, rs2_ad, dec_rd;
  logic            hazard;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_wd;
  logic            we3;
  logic [4:0]      ad3;
  logic [XLEN-1:0] wd3;
  logic            busy;

  typedef struct packed {
    logic            we;
    logic [4:0]      ad;
    logic [XLEN-1:0] wd;
  } commit_t;

  commit_t         sb[$];
  commit_t         e;
  logic [4:0]      last_ad;
  logic [XLEN-1:0] last_wd;
  int              vectors    = 0;
  int              miscompares = 0;

  regfile_wb_sched #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1_ad    (rs1_ad),
    .rs2_ad    (rs2_ad),
    .dec_rd    (dec_rd),
    .hazard    (hazard),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_wd    (lsu_wd),
    .lsu_ready (lsu_ready),
    .we3       (we3),
    .ad3       (ad3),
    .wd3       (wd3),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected commit for a handshake: x0 writes leave ad3/wd3 holding.
  task automatic push_commit(input logic [4:0] rd, input logic [XLEN-1:0] wd);
    commit_t c;
    if (rd != 5'd0) begin
      last_ad = rd;
      last_wd = wd;
      c.we = 1'b1;
    end else begin
      c.we = 1'b0;
    end
    c.ad = last_ad;
    c.wd = last_wd;
    sb.push_back(c);
  endtask

  task automatic test_reset();
    // Readies must stay low while reset is held, even with both valids up.
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    vectors++;
    if ({we3, ad3, wd3, alu_ready, lsu_ready, busy, hazard} !== '0) begin
      miscompares++;
      $display("FAIL reset_init: got we3=%0b ad3=%0d wd3=%h ar=%0b lr=%0b busy=%0b hz=%0b, want all 0",
               we3, ad3, wd3, alu_ready, lsu_ready, busy, hazard);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    // Issue r9 and write it back in the same cycle, then reset mid-commit.
    iss_valid = 1'b1; iss_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_wd = 32'h0000_0099;
    tick();
    iss_valid = 1'b0;
    vectors++;
    if ({we3, ad3, wd3, busy} !== {1'b1, 5'd9, 32'h0000_0099, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_precommit: got we3=%0b ad3=%0d wd3=%h busy=%0b, want 1 9 00000099 1",
               we3, ad3, wd3, busy);
    end
    $display("commit we3=%0b ad3=%0d wd3=%h (before mid-cycle reset)", we3, ad3, wd3);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({we3, ad3, wd3, alu_ready, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got we3=%0b ad3=%0d wd3=%h alu_ready=%0b busy=%0b, want all 0",
               we3, ad3, wd3, alu_ready, busy);
    end
    alu_valid = 1'b0;
    last_ad = '0; last_wd = '0;
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if ({we3, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_after: got we3=%0b busy=%0b, want 0 0", we3, busy);
    end
  endtask

  task automatic test_single_alu();
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    rs1_ad = 5'd5;
    #1;
    vectors++;
    if ({hazard, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL single_issue: got hazard=%0b busy=%0b, want 1 1", hazard, busy);
    end
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready: got alu_ready=%0b lsu_ready=%0b, want 1 0", alu_ready, lsu_ready);
    end
    push_commit(alu_rd, alu_wd);
    tick();
    alu_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({we3, ad3, wd3} !== {e.we, e.ad, e.wd}) begin
      miscompares++;
      $display("FAIL single_commit: got we3=%0b ad3=%0d wd3=%h, want %0b %0d %h",
               we3, ad3, wd3, e.we, e.ad, e.wd);
    end
    $display("commit we3=%0b ad3=%0d wd3=%h (single ALU)", we3, ad3, wd3);
    vectors++;
    if (hazard !== 1'b1) begin
      miscompares++;
      $display("FAIL single_hazard_hold: got hazard=%0b, want 1", hazard);
    end
    tick();
    vectors++;
    if ({we3, hazard, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_hazard_drop: got we3=%0b hazard=%0b busy=%0b, want 0 0 0", we3, hazard, busy);
    end
    rs1_ad = 5'd0;
  endtask

  task automatic test_contention();
    int  st = 0;
    int  ai = 0;
    logic exp_a;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_wd = 32'hA000_0000;
    lsu_valid = 1'b1;
    // Expected grants: L L L A L L L A (counter back to 0 after ALU wins).
    for (int i = 0; i < 8; i++) begin
      lsu_rd = 5'(10 + i);
      lsu_wd = 32'hB000_0000 + 32'(i);
      #1;
      exp_a = (st == STARVE_MAX);
      vectors++;
      if ({alu_ready, lsu_ready} !== {exp_a, ~exp_a}) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: got alu_ready=%0b lsu_ready=%0b, want %0b %0b",
                 i, alu_ready, lsu_ready, exp_a, ~exp_a);
      end
      if (exp_a) push_commit(alu_rd, alu_wd);
      else       push_commit(lsu_rd, lsu_wd);
      st = exp_a ? 0 : ((st < STARVE_MAX) ? st + 1 : st);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({we3, ad3, wd3} !== {e.we, e.ad, e.wd}) begin
        miscompares++;
        $display("FAIL contention_commit[%0d]: got we3=%0b ad3=%0d wd3=%h, want %0b %0d %h",
                 i, we3, ad3, wd3, e.we, e.ad, e.wd);
      end
      $display("commit we3=%0b ad3=%0d wd3=%h (contention %0d, %s)", we3, ad3, wd3, i,
               exp_a ? "alu" : "lsu");
      if (exp_a) begin
        ai++;
        alu_rd = 5'(20 + ai);
        alu_wd = 32'hA000_0000 + 32'(ai);
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0;
    rs1_ad = 5'd0;
    #1;
    vectors++;
    if ({busy, hazard} !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_issue: got busy=%0b hazard=%0b, want 0 0", busy, hazard);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h0000_1234;
    #1;
    vectors++;
    if (lsu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_ready: got lsu_ready=%0b, want 1", lsu_ready);
    end
    push_commit(lsu_rd, lsu_wd);
    tick();
    lsu_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({we3, ad3, wd3, busy} !== {e.we, e.ad, e.wd, 1'b0}) begin
      miscompares++;
      $display("FAIL x0_commit: got we3=%0b ad3=%0d wd3=%h busy=%0b, want %0b %0d %h 0",
               we3, ad3, wd3, busy, e.we, e.ad, e.wd);
    end
    $display("commit we3=%0b ad3=%0d wd3=%h (x0 load)", we3, ad3, wd3);
  endtask

  task automatic test_collision();
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h0000_0077;
    push_commit(alu_rd, alu_wd);
    tick();
    alu_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({we3, ad3, wd3} !== {e.we, e.ad, e.wd}) begin
      miscompares++;
      $display("FAIL collision_commit: got we3=%0b ad3=%0d wd3=%h, want %0b %0d %h",
               we3, ad3, wd3, e.we, e.ad, e.wd);
    end
    $display("commit we3=%0b ad3=%0d wd3=%h (collision first write)", we3, ad3, wd3);
    // New producer for r7 issued in the commit cycle of the old one.
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    rs1_ad = 5'd7;
    #1;
    vectors++;
    if ({we3, busy, hazard} !== 3'b011) begin
      miscompares++;
      $display("FAIL collision_set_wins: got we3=%0b busy=%0b hazard=%0b, want 0 1 1", we3, busy, hazard);
    end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h0000_0078;
    push_commit(alu_rd, alu_wd);
    tick();
    alu_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({we3, ad3, wd3} !== {e.we, e.ad, e.wd}) begin
      miscompares++;
      $display("FAIL collision_second: got we3=%0b ad3=%0d wd3=%h, want %0b %0d %h",
               we3, ad3, wd3, e.we, e.ad, e.wd);
    end
    $display("commit we3=%0b ad3=%0d wd3=%h (collision second write)", we3, ad3, wd3);
    tick();
    vectors++;
    if ({busy, hazard} !== 2'b00) begin
      miscompares++;
      $display("FAIL collision_clear: got busy=%0b hazard=%0b, want 0 0", busy, hazard);
    end
    rs1_ad = 5'd0;
  endtask

  task automatic test_back_to_back();
    iss_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      iss_rd = 5'(k);
      tick();
    end
    iss_valid = 1'b0;
    lsu_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      lsu_rd = 5'(k);
      lsu_wd = 32'h0000_0100 + 32'(k);
      #1;
      vectors++;
      if (lsu_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got lsu_ready=%0b, want 1", k, lsu_ready);
      end
      push_commit(lsu_rd, lsu_wd);
      tick();
      if (k == 3) lsu_valid = 1'b0;
      e = sb.pop_front();
      vectors++;
      if ({we3, ad3, wd3} !== {e.we, e.ad, e.wd}) begin
        miscompares++;
        $display("FAIL b2b_commit[%0d]: got we3=%0b ad3=%0d wd3=%h, want %0b %0d %h",
                 k, we3, ad3, wd3, e.we, e.ad, e.wd);
      end
      $display("commit we3=%0b ad3=%0d wd3=%h (back-to-back %0d)", we3, ad3, wd3, k);
      // The register committing now is still pending; the previous one is clear.
      rs1_ad = 5'(k);
      #1;
      vectors++;
      if (hazard !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_pend_hold[%0d]: got hazard=%0b, want 1", k, hazard);
      end
      if (k > 1) begin
        rs1_ad = 5'(k - 1);
        #1;
        vectors++;
        if (hazard !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_pend_clear[%0d]: got hazard=%0b, want 0", k - 1, hazard);
        end
      end
    end
    tick();
    rs1_ad = 5'd3;
    #1;
    vectors++;
    if ({we3, hazard, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL b2b_drain: got we3=%0b hazard=%0b busy=%0b, want 0 0 0", we3, hazard, busy);
    end
    rs1_ad = 5'd0;
  endtask

  initial begin
    rst_n = 1'b1;
    iss_valid = 1'b0; iss_rd = '0;
    rs1_ad = '0; rs2_ad = '0; dec_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    last_ad = '0; last_wd = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_single_alu();
    test_contention();
    test_x0();
    test_collision();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and scoreboard for the 32x32 integer register file. Two writeback sources, the ALU pipe and the load/store unit, share the register file's single write port (ad3/wd3/we3). This block arbitrates between them, with starvation protection for the ALU. It also tracks which architectural registers have an outstanding write, and raises a hazard to decode until that write has committed. It sits between execute/memory writeback and the register file; the register file resets synchronously, but this block does not.

## Interface
- XLEN, 32: data width of write data.
- STARVE_MAX, 3: consecutive cycles ALU may be denied before it gets priority; range 1..15.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- iss_valid  in  1  decode issues an instruction that writes iss_rd.
- iss_rd  in  5  destination of the issued instruction.
- rs1_ad  in  5  decode source 1 address.
- rs2_ad  in  5  decode source 2 address.
- dec_rd  in  5  decode destination address (WAW check).
- hazard  out  1  combinational: decode must stall.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination.
- alu_wd  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  load writeback request.
- lsu_rd  in  5  load destination.
- lsu_wd  in  XLEN  load data.
- lsu_ready  out  1  load request accepted this cycle.
- we3  out  1  register-file write enable (registered).
- ad3  out  5  register-file write address (registered).
- wd3  out  XLEN  register-file write data (registered).
- busy  out  1  any pending bit set.

## Operation
- Scoreboard: pend[31:0], pend[0] hard-wired 0.
  - Set pend[iss_rd] on iss_valid with iss_rd != 0.
  - Clear pend[ad3] on a cycle where we3=1.
  - Same register set and cleared in the same cycle: set wins (new producer).
- hazard = (rs1_ad!=0 & pend[rs1_ad]) | (rs2_ad!=0 & pend[rs2_ad]) | (dec_rd!=0 & pend[dec_rd]).
  - Decode never issues while hazard=1.
  - Issuing to an already-pending rd is a protocol violation; the bit stays set.
- Arbitration, one grant per cycle:
  - Only one source valid: grant it.
  - Both valid: grant LSU, unless starve_cnt == STARVE_MAX, then grant ALU.
- starve_cnt, 4 bits:
  - Increments, saturating at STARVE_MAX, when alu_valid=1 and ALU is not granted.
  - Cleared when ALU is granted or alu_valid=0.
- alu_ready / lsu_ready = grant for that source; combinational from the valids and starve_cnt.
  - Both are forced 0 while rst_n=0.
- Handshake: transfer occurs when valid & ready.
  - A source holds valid, rd and wd stable until ready.
  - A source does not drop valid without a transfer.
- Commit, on the edge after a transfer:
  - rd != 0: we3=1, ad3=rd, wd3=wd.
  - rd == 0: we3=0; ad3/wd3 hold their previous values; no pend change.
- No transfer in a cycle: we3=0 on the next edge; ad3/wd3 hold.
- busy = |pend.

## Timing
- Reset (asynchronous, immediate): pend=0, starve_cnt=0, we3=0, ad3=0, wd3=0. Consequently hazard=0, busy=0, alu_ready=0, lsu_ready=0.
- Deassertion of reset is synchronized by the integrating top; the first active edge may accept a transfer.
- Latency:
  - Transfer at edge N: we3 is high during cycle N..N+1.
  - The register file writes at edge N+1, which is also when pend clears.
  - Decode sees hazard drop in the cycle after edge N+1 and reads the new value combinationally.
- No bypass: a dependent instruction stalls 2 cycles minimum after the transfer edge.
- Throughput: one write per cycle; back-to-back transfers keep we3 continuously high.
- Reset mid-operation aborts any in-flight commit; the register file is not written.

## Test plan
- Reset: drive rst_n=0 mid-cycle with alu_valid=1 -> we3, ad3, wd3, ready outputs and busy go 0 immediately without a clock edge.
- Single ALU write:
  - Issue rd=5; alu_valid, rd=5, wd=0xDEADBEEF.
  - alu_ready=1 -> next cycle we3=1, ad3=5, wd3=0xDEADBEEF.
  - hazard with rs1_ad=5 stays 1 through that cycle and drops after.
- Contention, STARVE_MAX=3:
  - Both valid continuously, LSU re-presenting new requests each cycle.
  - LSU granted 3 cycles, then ALU on the 4th; starve_cnt then returns to 0.
- x0 handling:
  - iss_rd=0 leaves pend unchanged.
  - A transfer with lsu_rd=0 completes the handshake with we3=0.
  - hazard stays 0 for rs1_ad=0.
- Set/clear collision:
  - we3=1, ad3=7 in the same cycle as iss_valid with iss_rd=7 -> pend[7] remains 1 and busy=1.
- Back-to-back: LSU writes regs 1, 2, 3 on consecutive cycles -> we3 high 3 consecutive cycles with ad3=1, 2, 3, and pend bits clear in order.
